node_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one processing-node input among NREQ requesters.

---
 rtl/node_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_node_rr_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_rr_scheduler.sv
// Round-robin scheduler sharing one node input among NREQ requesters.
// Grants one source at a time and delivers its latched operand via valid/ready.
module node_rr_scheduler #(
  parameter  int NREQ     = 4,
  parameter  int DW       = 4,
  parameter  int HOLD_MAX = 15,
  localparam int SRCW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              node_valid,
  output logic [DW-1:0]     node_data,
  output logic [SRCW-1:0]   node_src,
  input  logic              node_ready,
  output logic              abort,
  output logic [7:0]        xfer_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_n;
  logic [SRCW-1:0] last_ptr, last_ptr_n;
  logic [7:0]      hold_cnt, hold_cnt_n;
  logic [NREQ-1:0] cand;
  logic [SRCW-1:0] win;
  logic            win_vld;
  logic            timeout;
  logic [NREQ-1:0] gnt_n, ack_n;
  logic            node_valid_n, abort_n;
  logic [DW-1:0]   node_data_n;
  logic [SRCW-1:0] node_src_n;
  logic [7:0]      xfer_cnt_n;

  // the source acked last cycle still shows its stale req
  assign cand    = req & ~ack;
  assign timeout = (hold_cnt == 8'(HOLD_MAX - 1));

  always_comb begin : pick
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_ptr) + k) % NREQ;
      if (!win_vld && cand[idx]) begin
        win     = SRCW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_ptr   <= SRCW'(NREQ - 1);
      hold_cnt   <= '0;
      gnt        <= '0;
      ack        <= '0;
      node_valid <= 1'b0;
      node_data  <= '0;
      node_src   <= '0;
      abort      <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      state      <= state_n;
      last_ptr   <= last_ptr_n;
      hold_cnt   <= hold_cnt_n;
      gnt        <= gnt_n;
      ack        <= ack_n;
      node_valid <= node_valid_n;
      node_data  <= node_data_n;
      node_src   <= node_src_n;
      abort      <= abort_n;
      xfer_cnt   <= xfer_cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (ena && win_vld) state_n = SEND;
      SEND: if (node_ready || timeout) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_n        = gnt;
    ack_n        = '0;
    node_valid_n = node_valid;
    node_data_n  = node_data;
    node_src_n   = node_src;
    abort_n      = 1'b0;
    xfer_cnt_n   = xfer_cnt;
    last_ptr_n   = last_ptr;
    hold_cnt_n   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (ena && win_vld) begin
          gnt_n        = NREQ'(1) << win;
          node_valid_n = 1'b1;
          node_data_n  = req_data[win*DW +: DW];
          node_src_n   = win;
          hold_cnt_n   = '0;
        end
      end
      SEND: begin
        if (node_ready) begin
          ack_n        = gnt;
          xfer_cnt_n   = xfer_cnt + 8'd1;
          last_ptr_n   = node_src;
          gnt_n        = '0;
          node_valid_n = 1'b0;
        end else if (timeout) begin
          abort_n      = 1'b1;
          last_ptr_n   = node_src;
          gnt_n        = '0;
          node_valid_n = 1'b0;
        end else begin
          hold_cnt_n   = hold_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_node_rr_scheduler.sv
// Bench for node_rr_scheduler: directed scenarios plus random traffic
// compared each cycle against a transaction-level model.
module tb_node_rr_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int HM   = 15;
  localparam int SW   = $clog2(NREQ);

  logic              clk = 0;
  logic              rst_n = 0;
  logic              ena = 0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   gnt, ack;
  logic              node_valid, abort;
  logic [DW-1:0]     node_data;
  logic [SW-1:0]     node_src;
  logic              node_ready = 0;
  logic [7:0]        xfer_cnt;

  int errors = 0;
  int checks = 0;

  node_rr_scheduler #(.NREQ(NREQ), .DW(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
    .req_data(req_data), .gnt(gnt), .ack(ack),
    .node_valid(node_valid), .node_data(node_data),
    .node_src(node_src), .node_ready(node_ready),
    .abort(abort), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // model: one in-flight transfer, cycles spent offering it,
  // rotation pointer, last-cycle ack vector and accepted count
  logic            m_busy, m_abort;
  logic [NREQ-1:0] m_ack, a_v;
  logic [DW-1:0]   m_data;
  logic [7:0]      m_cnt;
  int              m_src, m_last, m_age, w;

  function automatic int rr_pick(input logic [NREQ-1:0] c,
                                 input int last);
    for (int k = 1; k <= NREQ; k++)
      if (c[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_abort = 0; m_ack = '0; m_data = '0;
      m_cnt = '0; m_src = 0; m_last = NREQ - 1; m_age = 0;
    end else begin
      a_v = '0;
      m_abort = 0;
      if (!m_busy) begin
        w = ena ? rr_pick(req & ~m_ack, m_last) : -1;
        if (w >= 0) begin
          m_busy = 1; m_src = w; m_age = 0;
          m_data = req_data[w*DW +: DW];
        end
      end else begin
        m_age++;
        if (node_ready) begin
          a_v[m_src] = 1'b1;
          m_cnt = m_cnt + 8'd1;
          m_last = m_src;
          m_busy = 0;
        end else if (m_age == HM) begin
          m_abort = 1;
          m_last = m_src;
          m_busy = 0;
        end
      end
      m_ack = a_v;
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] e_gnt;
    if (rst_n) begin
      e_gnt = m_busy ? (NREQ'(1) << m_src) : '0;
      checks++;
      if (gnt !== e_gnt || ack !== m_ack ||
          node_valid !== m_busy || node_data !== m_data ||
          node_src !== SW'(m_src) || abort !== m_abort ||
          xfer_cnt !== m_cnt) begin
        errors++;
        $display("FAIL model t=%0t gnt=%b/%b ack=%b/%b vld=%b/%b dat=%h/%h src=%0d/%0d abt=%b/%b cnt=%0d/%0d",
          $time, gnt, e_gnt, ack, m_ack, node_valid, m_busy,
          node_data, m_data, node_src, m_src, abort, m_abort,
          xfer_cnt, m_cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req = '0; ena = 1; node_ready = 0;
    req_data = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  int nv, na, nk, g, stall;
  int srcs[$];
  int dats[$];

  initial begin
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", node_valid, 0);
    chk("rst_cnt", xfer_cnt, 0);

    // single transfer
    req = 4'b0001; req_data = 16'h000A; node_ready = 1;
    step();
    chk("t1_valid", node_valid, 1);
    chk("t1_data", node_data, 4'hA);
    chk("t1_src", node_src, 0);
    chk("t1_gnt", gnt, 4'b0001);
    req = '0;
    step();
    chk("t1_ack", ack, 4'b0001);
    chk("t1_gnt_off", gnt, 0);
    chk("t1_cnt", xfer_cnt, 1);
    chk("t1_model_cnt", m_cnt, 1);

    // all requesting: pure rotation
    do_reset();
    req = 4'b1111; req_data = 16'h8765; node_ready = 1;
    for (int i = 0; i < 40 && srcs.size() < 5; i++) begin
      step();
      if (node_valid) begin
        srcs.push_back(int'(node_src));
        dats.push_back(int'(node_data));
      end
    end
    chk("t2_ngrants", srcs.size(), 5);
    for (int i = 0; i < 5 && i < srcs.size(); i++) begin
      chk("t2_src", srcs[i], i % 4);
      chk("t2_data", dats[i], 5 + i % 4);
    end

    // dead node: timeout then rotation past the aborted source
    do_reset();
    req = 4'b0100; node_ready = 0;
    nv = 0; na = 0; nk = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (node_valid) nv++;
      if (abort) begin na++; req = '0; end
      if (ack != 0) nk++;
    end
    chk("t3_valid_cycles", nv, 15);
    chk("t3_aborts", na, 1);
    chk("t3_acks", nk, 0);
    chk("t3_cnt", xfer_cnt, 0);
    req = 4'b0110;
    g = 0;
    for (int i = 0; i < 5 && !g; i++) begin
      step();
      if (node_valid) g = 1;
    end
    chk("t3_regrant", g, 1);
    chk("t3_src", node_src, 1);
    req = '0; node_ready = 1;
    step();

    // inputs ignored during SEND
    do_reset();
    req = 4'b0100; req_data = 16'h0300; node_ready = 0;
    step();
    chk("t4_src", node_src, 2);
    chk("t4_data0", node_data, 3);
    req = '0; req_data = 16'h0F00;
    repeat (3) begin
      step();
      chk("t4_hold", node_data, 3);
    end
    node_ready = 1;
    step();
    chk("t4_ack", ack, 4'b0100);
    chk("t4_data_end", node_data, 3);
    node_ready = 0;

    // ena gating
    do_reset();
    ena = 0; req = 4'b1111; node_ready = 1;
    g = 0;
    repeat (5) begin step(); if (gnt != 0) g++; end
    chk("t5_no_gnt", g, 0);
    ena = 1;
    step();
    chk("t5_gnt", gnt, 4'b0001);
    ena = 0; node_ready = 0;
    step();
    node_ready = 1;
    step();
    chk("t5_ack", ack, 4'b0001);
    g = 0;
    repeat (6) begin step(); if (gnt != 0) g++; end
    chk("t5_stop", g, 0);

    // async reset mid-SEND
    do_reset();
    req = 4'b0010; node_ready = 1;
    step();
    req = '0;
    step();
    req = 4'b0001; node_ready = 0;
    step();
    chk("t6_pre_valid", node_valid, 1);
    chk("t6_pre_cnt", xfer_cnt, 1);
    #3 rst_n = 0;
    #1;
    chk("t6_gnt", gnt, 0);
    chk("t6_valid", node_valid, 0);
    chk("t6_ack", ack, 0);
    chk("t6_cnt", xfer_cnt, 0);
    req = 4'b0110; node_ready = 1;
    #2 rst_n = 1;
    step();
    chk("t6_src", node_src, 1);

    // random traffic against the model
    stall = 0;
    for (int i = 0; i < 1500; i++) begin
      req = NREQ'($urandom);
      req_data = (NREQ*DW)'($urandom);
      ena = ($urandom_range(0, 9) != 0);
      if (stall > 0) begin
        node_ready = 0;
        stall--;
      end else if ($urandom_range(0, 99) < 3) begin
        stall = $urandom_range(10, 20);
        node_ready = 0;
      end else begin
        node_ready = 1'($urandom_range(0, 1));
      end
      step();
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
